// File: rtl/aclk_timegen_if.sv
// aclk_timegen_if -- signal bundle between the alarm-clock time generator and
// its consumer.
//   reset_count : clear divider and seconds count (consumer -> generator)
//   fast_watch  : fast-time request (consumer -> generator)
//   one_second  : one-cycle pulse per second (generator -> consumer)
//   one_minute  : one-cycle pulse advancing the minute counter
//   sec_ms      : BCD tens of seconds, 0..5
//   sec_ls      : BCD units of seconds, 0..9
// Modports: master = time generator side, slave = consumer side.
interface aclk_timegen_if;
  logic       reset_count;
  logic       fast_watch;
  logic       one_second;
  logic       one_minute;
  logic [3:0] sec_ms;
  logic [3:0] sec_ls;

  modport master (
    input  reset_count,
    input  fast_watch,
    output one_second,
    output one_minute,
    output sec_ms,
    output sec_ls
  );

  modport slave (
    output reset_count,
    output fast_watch,
    input  one_second,
    input  one_minute,
    input  sec_ms,
    input  sec_ls
  );
endinterface

// File: rtl/aclk_timegen.sv
// aclk_timegen -- alarm-clock seconds generator.
// Divides clk by CLK_PER_SEC to produce a one-cycle one_second pulse, keeps a
// BCD seconds count 00..59 and pulses one_minute on the 59->00 wrap.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; overrides everything
//   tg    : aclk_timegen_if.master (reset_count, fast_watch in;
//           one_second, one_minute, sec_ms, sec_ls out, all registered)
// Parameter:
//   CLK_PER_SEC : clk cycles per second, 2..65535
// Build option:
//   ACLK_TIMEGEN_FAST_WATCH_EN : when defined, fast_watch sampled at a
//   one_second pulse turns that pulse into a minute advance and holds the
//   seconds at 00. When undefined, fast_watch is ignored.
module aclk_timegen #(
  parameter int unsigned CLK_PER_SEC = 256
) (
  input  logic           clk,
  input  logic           reset,
  aclk_timegen_if.master tg
);

  localparam int unsigned      DIV_W    = $clog2(CLK_PER_SEC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SEC - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic             one_second_q;
  logic             one_minute_q;
  logic [3:0]       sec_ms_q;
  logic [3:0]       sec_ls_q;

  // Next BCD value of the seconds count and its wrap flag
  logic [3:0] sec_ms_inc;
  logic [3:0] sec_ls_inc;
  logic       sec_wrap;
  logic       div_last;
  logic       fast_sel;

  assign div_last = (div_q == DIV_LAST);

`ifdef ACLK_TIMEGEN_FAST_WATCH_EN
  // Sampled only on a pulse edge, so a change takes effect at the next second.
  assign fast_sel = tg.fast_watch;
`else
  logic unused_fast_watch;
  assign unused_fast_watch = tg.fast_watch;
  assign fast_sel          = 1'b0;
`endif

  always_comb begin
    sec_ms_inc = sec_ms_q;
    sec_ls_inc = sec_ls_q + 4'd1;
    sec_wrap   = 1'b0;
    if (sec_ls_q >= 4'd9) begin
      sec_ls_inc = 4'd0;
      if (sec_ms_q >= 4'd5) begin
        sec_ms_inc = 4'd0;
        sec_wrap   = 1'b1;
      end else begin
        sec_ms_inc = sec_ms_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || tg.reset_count) begin
      div_q        <= '0;
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
      sec_ms_q     <= '0;
      sec_ls_q     <= '0;
    end else begin
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
      if (div_last) begin
        div_q        <= '0;
        one_second_q <= 1'b1;
        if (fast_sel) begin
          one_minute_q <= 1'b1;
          sec_ms_q     <= '0;
          sec_ls_q     <= '0;
        end else begin
          one_minute_q <= sec_wrap;
          sec_ms_q     <= sec_ms_inc;
          sec_ls_q     <= sec_ls_inc;
        end
      end else begin
        div_q <= div_q + DIV_ONE;
      end
    end
  end

  assign tg.one_second = one_second_q;
  assign tg.one_minute = one_minute_q;
  assign tg.sec_ms     = sec_ms_q;
  assign tg.sec_ls     = sec_ls_q;

endmodule

// File: tb/tb_aclk_timegen.sv
// tb_aclk_timegen -- scoreboard bench for aclk_timegen with CLK_PER_SEC=4.
// The stimulus process drives inputs on the falling edge and pushes the
// expected post-edge outputs, computed from elapsed-cycle and seconds
// integers, into a queue; the monitor pops and compares after each rising
// edge. Honours ACLK_TIMEGEN_FAST_WATCH_EN the same way as the design.
module tb_aclk_timegen;

  localparam int unsigned N = 4;
`ifdef ACLK_TIMEGEN_FAST_WATCH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct packed {
    logic       os;
    logic       om;
    logic [3:0] ms;
    logic [3:0] ls;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  aclk_timegen_if tg ();

  aclk_timegen #(.CLK_PER_SEC(N)) dut (
    .clk   (clk),
    .reset (reset),
    .tg    (tg)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference state: cycles elapsed in the current second, seconds of minute
  int   m_elapsed = 0;
  int   m_secs    = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  task automatic step(input logic r, input logic rc, input logic fw);
    exp_t e;
    @(negedge clk);
    reset          = r;
    tg.reset_count = rc;
    tg.fast_watch  = fw;
    e = '0;
    if (r || rc) begin
      m_elapsed = 0;
      m_secs    = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed == N) begin
        m_elapsed = 0;
        e.os      = 1'b1;
        if (FAST && fw) begin
          m_secs = 0;
          e.om   = 1'b1;
        end else begin
          m_secs = (m_secs + 1) % 60;
          e.om   = (m_secs == 0);
        end
      end
    end
    e.ms = 4'(m_secs / 10);
    e.ls = 4'(m_secs % 10);
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("one_second", int'(tg.one_second), int'(e.os));
        check("one_minute", int'(tg.one_minute), int'(e.om));
        check("sec_ms",     int'(tg.sec_ms),     int'(e.ms));
        check("sec_ls",     int'(tg.sec_ls),     int'(e.ls));
        check("minute_implies_second",
              int'(tg.one_minute && !tg.one_second), 0);
        check("bcd_range",
              int'(tg.sec_ms > 4'd5 || tg.sec_ls > 4'd9), 0);
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic fw;
    int   rc_hold;
    reset          = 1'b1;
    tg.reset_count = 1'b0;
    tg.fast_watch  = 1'b0;

    // Reset, then free-run past the first minute wrap (cycle 240)
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b0, 1'b0, 1'b0);

    // reset_count while the divider holds its last value
    for (int k = 0; k < 2 * N && m_elapsed != N - 1; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3 * N; i++) step(1'b0, 1'b0, 1'b0);

    // reset_count held for several cycles
    for (int i = 0; i < 3 * N; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2 * N; i++) step(1'b0, 1'b0, 1'b0);

    // Fast-watch run, then back to normal
    for (int i = 0; i < 5 * N; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12 * N; i++) step(1'b0, 1'b0, 1'b0);

    // Reach seconds 37, then reset together with reset_count and fast_watch
    for (int k = 0; k < 61 * N && m_secs != 37; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3 * N; i++) step(1'b0, 1'b0, 1'b0);

    // Randomized traffic
    fw      = 1'b0;
    rc_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) fw = ~fw;
      if (rc_hold == 0 && $urandom_range(0, 59) == 0) rc_hold = $urandom_range(1, 3);
      step(logic'($urandom_range(0, 149) == 0), logic'(rc_hold != 0), fw);
      if (rc_hold != 0) rc_hold--;
    end

    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
